// File: rtl/bcd_scan_counter.sv
// Cascaded BCD up/down counter with runtime prescaler and multiplexed 7-segment scan.
// Define BCD_SCAN_COUNTER_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_scan_counter #(
  parameter int          DIGITS    = 4,
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter int          SCAN_W    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [7:0]            cmp_in,
  output logic [4*DIGITS-1:0]   count,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  wrap
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [23:0]          presc;
  logic [23:0]          cmp;
  logic                 tick;
  logic [4*DIGITS-1:0]  next_cnt;
  logic [4*DIGITS-1:0]  load_clean;
  logic                 full_wrap;
  logic                 carry;
  logic [3:0]           cur_d;
  logic [3:0]           new_d;
  logic [SCAN_W-1:0]    scan_div;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           shown;

  assign cmp  = (cmp_in == 8'd0) ? MAX_COUNT : {6'b0, cmp_in, 10'b0};
  assign tick = (presc == cmp);

  // If cmp drops below presc, the counter simply runs through its 24-bit wrap.
  always_ff @(posedge clk) begin
    if (reset)
      presc <= 24'd0;
    else if (tick)
      presc <= 24'd0;
    else
      presc <= presc + 24'd1;
  end

  always_comb begin
    next_cnt = count;
    carry    = 1'b1;
    cur_d    = 4'd0;
    new_d    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_d = count[4*i +: 4];
      new_d = cur_d;
      if (carry) begin
        if (up_dn) begin
          if (cur_d >= 4'd9) begin
            new_d = 4'd0;
          end else begin
            new_d = cur_d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (cur_d == 4'd0) begin
            new_d = 4'd9;
          end else begin
            new_d = cur_d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      next_cnt[4*i +: 4] = new_d;
    end
    full_wrap = carry;
  end

  always_comb begin
    load_clean = '0;
    for (int i = 0; i < DIGITS; i++)
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= load_clean;
      end else if (tick && enable) begin
        count <= next_cnt;
        wrap  <= full_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_div <= '0;
      idx      <= '0;
    end else begin
      scan_div <= scan_div + SCAN_W'(1);
      if (&scan_div)
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  generate
    if (DIGITS == 1) begin : g_one
      assign dig_sel = 1'b1;
    end else begin : g_many
      assign dig_sel = DIGITS'(1) << idx;
    end
  endgenerate

  assign shown = count[{idx, 2'b00} +: 4];

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7C;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h67;
      default: decode = 7'h00;
    endcase
  endfunction

`ifdef BCD_SCAN_COUNTER_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  logic              higher_zero;

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    lead_zero   = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead_zero[i] = higher_zero && (count[4*i +: 4] == 4'd0);
      higher_zero  = lead_zero[i];
    end
  end

  assign seg = lead_zero[idx] ? 7'h00 : decode(shown);
`else
  assign seg = decode(shown);
`endif

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter: step/wrap vectors, load priority, sanitising, scan, reset.
module tb_bcd_scan_counter;

  localparam int DIGITS = 4;
  localparam int SCAN_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [7:0]  cmp_in;
  logic [15:0] count;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        wrap;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bcd_scan_counter #(.DIGITS(DIGITS), .MAX_COUNT(24'd10_000_000), .SCAN_W(SCAN_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .cmp_in(cmp_in), .count(count), .seg(seg),
    .dig_sel(dig_sel), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; with cmp_in=1 a step lands when this reaches 1025.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  typedef struct {
    logic [15:0] ld;
    logic        up;
    logic [15:0] exp_cnt;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    tick_clk();
    reset = 1'b0;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick_clk();
  endtask

  task automatic scan_check(input string name, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg[4];
    int k;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int n = 0; n < 16; n++) begin
      k = (cyc / 4) % 4;
      check({name, "_dig_sel"}, {28'd0, dig_sel}, 32'd1 << k);
      check({name, "_seg"}, {25'd0, seg}, {25'd0, exp_seg[k]});
      tick_clk();
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    enable   = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 16'h0000;
    cmp_in   = 8'd1;

    vecs[0] = '{16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[1] = '{16'h9999, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 1'b0, 16'h9999, 1'b1};
    vecs[3] = '{16'h0100, 1'b0, 16'h0099, 1'b0};
    vecs[4] = '{16'h0199, 1'b1, 16'h0200, 1'b0};
    vecs[5] = '{16'h1239, 1'b1, 16'h1240, 1'b0};
    vecs[6] = '{16'h9990, 1'b0, 16'h9989, 1'b0};

    tick_clk();
    do_reset();
    check("reset_count", {16'd0, count}, 32'h0);
    check("reset_wrap", {31'd0, wrap}, 32'h0);
    check("reset_dig_sel", {28'd0, dig_sel}, 32'h1);
    check("reset_seg", {25'd0, seg}, 32'h3F);

    // Step vectors: load, then wait for the single tick after reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      enable   = 1'b1;
      up_dn    = vecs[i].up;
      load     = 1'b1;
      load_val = vecs[i].ld;
      tick_clk();
      load = 1'b0;
      n = 0;
      while (count === vecs[i].ld && n < 1100) begin
        tick_clk();
        n++;
      end
      check($sformatf("vec%0d_latency", i), cyc, 32'd1025);
      check($sformatf("vec%0d_count", i), {16'd0, count}, {16'd0, vecs[i].exp_cnt});
      check($sformatf("vec%0d_wrap", i), {31'd0, wrap}, {31'd0, vecs[i].exp_wrap});
      tick_clk();
      check($sformatf("vec%0d_wrap_fall", i), {31'd0, wrap}, 32'h0);
    end

    // Load held through the tick cycle wins; next tick then increments.
    do_reset();
    enable   = 1'b1;
    up_dn    = 1'b1;
    load     = 1'b1;
    load_val = 16'h1234;
    run_until(1025);
    check("load_prio_count", {16'd0, count}, 32'h1234);
    check("load_prio_wrap", {31'd0, wrap}, 32'h0);
    load = 1'b0;
    run_until(2049);
    check("post_load_hold", {16'd0, count}, 32'h1234);
    tick_clk();
    check("post_load_step", {16'd0, count}, 32'h1235);

    // Illegal digits load as zero; disabled counting ignores the tick.
    do_reset();
    enable   = 1'b0;
    load     = 1'b1;
    load_val = 16'hA3F5;
    tick_clk();
    load = 1'b0;
    check("sanitize_count", {16'd0, count}, 32'h0305);
    run_until(1030);
    check("disabled_count", {16'd0, count}, 32'h0305);
    check("disabled_wrap", {31'd0, wrap}, 32'h0);

    do_reset();
    load     = 1'b1;
    load_val = 16'h1234;
    tick_clk();
    load = 1'b0;
    scan_check("scan1234", 7'h66, 7'h4F, 7'h5B, 7'h06);

    do_reset();
    load     = 1'b1;
    load_val = 16'h0007;
    tick_clk();
    load = 1'b0;
`ifdef BCD_SCAN_COUNTER_ZERO_BLANK_EN
    scan_check("scan0007", 7'h07, 7'h00, 7'h00, 7'h00);
`else
    scan_check("scan0007", 7'h07, 7'h3F, 7'h3F, 7'h3F);
`endif

    // Reset beats a simultaneous load.
    load     = 1'b1;
    load_val = 16'h0042;
    tick_clk();
    reset    = 1'b1;
    load_val = 16'h5555;
    tick_clk();
    reset = 1'b0;
    load  = 1'b0;
    check("midreset_count", {16'd0, count}, 32'h0);
    check("midreset_wrap", {31'd0, wrap}, 32'h0);
    check("midreset_dig_sel", {28'd0, dig_sel}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
